fpu_pre_norm: RTL and testbench

FPU_PRE_NORM -- requirements
Module: fpu_pre_norm

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_pre_norm_if.sv | 32 +++
 rtl/fpu_unpack.sv | 30 +++
 rtl/fpu_pre_norm.sv | 155 +++++++++++++++
 tb/tb_fpu_pre_norm.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision add/sub pre-normalisation stage.
package fpu_pkg;

   localparam int EXP_W     = 8;
   localparam int MAN_W     = 23;
   localparam int ALIGN_MAX = 25;
   localparam int CNT_W     = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_DONE
   } state_e;

   localparam logic [3:0] EXC_NONE  = 4'b0000;
   localparam logic [3:0] EXC_NAN   = 4'b0001;
   localparam logic [3:0] EXC_INF   = 4'b0010;
   localparam logic [3:0] EXC_AZERO = 4'b0100;
   localparam logic [3:0] EXC_BZERO = 4'b1000;

endpackage

// File: rtl/fpu_pre_norm_if.sv
// Operand/result handshake bundle between the issuing stage, pre-norm and the adder.
interface fpu_pre_norm_if;
   import fpu_pkg::*;

   logic             valid_i;
   logic             ready_o;
   logic [31:0]      a_i;
   logic [31:0]      b_i;
   logic             sub_i;
   logic             valid_o;
   logic             ready_i;
   logic             sign_o;
   logic             eff_sub_o;
   logic [EXP_W-1:0] exp_o;
   logic [MAN_W:0]   man_big_o;
   logic [MAN_W:0]   man_small_o;
   logic             sticky_o;
   logic [3:0]       exception_o;

   modport slave (
      input  valid_i, a_i, b_i, sub_i, ready_i,
      output ready_o, valid_o, sign_o, eff_sub_o, exp_o,
             man_big_o, man_small_o, sticky_o, exception_o
   );

   modport master (
      output valid_i, a_i, b_i, sub_i, ready_i,
      input  ready_o, valid_o, sign_o, eff_sub_o, exp_o,
             man_big_o, man_small_o, sticky_o, exception_o
   );

endinterface

// File: rtl/fpu_unpack.sv
// Combinational IEEE-754 single field split and special-value classification.
module fpu_unpack
   import fpu_pkg::*;
(
   input  logic [31:0]      op_i,
   output logic             sign_o,
   output logic [EXP_W-1:0] exp_o,
   output logic [MAN_W:0]   man_o,
   output logic             nan_o,
   output logic             inf_o,
   output logic             zero_o
);

   logic [EXP_W-1:0] exp_raw;
   logic [MAN_W-1:0] frac;

   assign exp_raw = op_i[30:23];
   assign frac    = op_i[22:0];

   // Denormals share the exponent of the smallest normal, with hidden bit 0.
   always_comb begin
      sign_o = op_i[31];
      exp_o  = (exp_raw == '0) ? EXP_W'(1) : exp_raw;
      man_o  = {(exp_raw != '0), frac};
      nan_o  = (exp_raw == '1) && (frac != '0);
      inf_o  = (exp_raw == '1) && (frac == '0);
      zero_o = (exp_raw == '0) && (frac == '0);
   end

endmodule

// File: rtl/fpu_pre_norm.sv
// Add/sub pre-normalisation: operand swap and serial right-alignment of the smaller mantissa.
// state  | meaning
// IDLE   | ready for a new operand pair
// UNPACK | classify, swap, compute shift amount
// ALIGN  | shift smaller mantissa one bit per cycle
// DONE   | result valid, held until downstream accepts
module fpu_pre_norm
   import fpu_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_ni,
   fpu_pre_norm_if.slave pn_if
);

   state_e           state_q, state_d;
   logic [31:0]      a_q, a_d, b_q, b_d;
   logic             sub_q, sub_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sign_q, sign_d, eff_sub_q, eff_sub_d, sticky_q, sticky_d;
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [MAN_W:0]   man_big_q, man_big_d, man_small_q, man_small_d;
   logic [3:0]       exc_q, exc_d;

   logic             sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W:0]   ma, mb;

   fpu_unpack u_unpack_a (.op_i(a_q), .sign_o(sa), .exp_o(ea), .man_o(ma),
                          .nan_o(nan_a), .inf_o(inf_a), .zero_o(zero_a));
   fpu_unpack u_unpack_b (.op_i(b_q), .sign_o(sb), .exp_o(eb), .man_o(mb),
                          .nan_o(nan_b), .inf_o(inf_b), .zero_o(zero_b));

   logic             sign_b_eff, eff_sub, a_big, big_sign, cls_sign;
   logic [EXP_W-1:0] big_exp, small_exp, diff;
   logic [MAN_W:0]   big_man, small_man;
   logic [CNT_W-1:0] n_shift;
   logic [3:0]       cls_exc;

   always_comb begin
      sign_b_eff = sb ^ sub_q;
      eff_sub    = sa ^ sign_b_eff;
      a_big      = {ea, ma} >= {eb, mb};
      big_sign   = a_big ? sa : sign_b_eff;
      big_exp    = a_big ? ea : eb;
      small_exp  = a_big ? eb : ea;
      big_man    = a_big ? ma : mb;
      small_man  = a_big ? mb : ma;
      diff       = big_exp - small_exp;
      n_shift    = (diff > EXP_W'(ALIGN_MAX)) ? CNT_W'(ALIGN_MAX) : diff[CNT_W-1:0];
      cls_sign   = big_sign;
      cls_exc    = EXC_NONE;
      if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
         cls_exc = EXC_NAN;
      end else if (inf_a || inf_b) begin
         cls_exc  = EXC_INF;
         cls_sign = inf_a ? sa : sign_b_eff;
      end else if (zero_a) begin
         cls_exc = EXC_AZERO;
      end else if (zero_b) begin
         cls_exc = EXC_BZERO;
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sub_d       = sub_q;
      cnt_d       = cnt_q;
      sign_d      = sign_q;
      eff_sub_d   = eff_sub_q;
      exp_d       = exp_q;
      man_big_d   = man_big_q;
      man_small_d = man_small_q;
      sticky_d    = sticky_q;
      exc_d       = exc_q;
      case (state_q)
         S_IDLE: begin
            if (pn_if.valid_i) begin
               a_d     = pn_if.a_i;
               b_d     = pn_if.b_i;
               sub_d   = pn_if.sub_i;
               state_d = S_UNPACK;
            end
         end
         S_UNPACK: begin
            sign_d      = cls_sign;
            eff_sub_d   = eff_sub;
            exp_d       = big_exp;
            man_big_d   = big_man;
            man_small_d = small_man;
            sticky_d    = 1'b0;
            exc_d       = cls_exc;
            if ((cls_exc != EXC_NONE) || (n_shift == '0)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d   = n_shift;
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            man_small_d = man_small_q >> 1;
            sticky_d    = sticky_q | man_small_q[0];
            cnt_d       = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            if (pn_if.ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         eff_sub_q   <= 1'b0;
         exp_q       <= '0;
         man_big_q   <= '0;
         man_small_q <= '0;
         sticky_q    <= 1'b0;
         exc_q       <= EXC_NONE;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sub_q       <= sub_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         eff_sub_q   <= eff_sub_d;
         exp_q       <= exp_d;
         man_big_q   <= man_big_d;
         man_small_q <= man_small_d;
         sticky_q    <= sticky_d;
         exc_q       <= exc_d;
      end
   end

   assign pn_if.ready_o     = (state_q == S_IDLE);
   assign pn_if.valid_o     = (state_q == S_DONE);
   assign pn_if.sign_o      = sign_q;
   assign pn_if.eff_sub_o   = eff_sub_q;
   assign pn_if.exp_o       = exp_q;
   assign pn_if.man_big_o   = man_big_q;
   assign pn_if.man_small_o = man_small_q;
   assign pn_if.sticky_o    = sticky_q;
   assign pn_if.exception_o = exc_q;

endmodule

// File: tb/tb_fpu_pre_norm.sv
// Directed bench for fpu_pre_norm: latency, alignment, exceptions, stall and reset abort.
module tb_fpu_pre_norm;
   import fpu_pkg::*;

   logic clk_i = 1'b0;
   logic rst_ni;
   int   checks   = 0;
   int   failures = 0;

   fpu_pre_norm_if bus ();

   fpu_pre_norm dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .pn_if (bus)
   );

   always #5 clk_i = ~clk_i;

   // Accept one operand pair; lat = edges after the accept edge until valid_o is seen (-1 on timeout).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
      int  i;
      bit  seen;
      @(negedge clk_i);
      bus.a_i = a; bus.b_i = b; bus.sub_i = s; bus.valid_i = 1'b1; bus.ready_i = 1'b0;
      @(posedge clk_i);
      #1;
      bus.valid_i = 1'b0; bus.a_i = 32'hFFFF_FFFF; bus.b_i = 32'h7FC0_0001; bus.sub_i = ~s;
      lat  = -1;
      seen = 1'b0;
      i    = 1;
      while (!seen && i <= 60) begin
         @(posedge clk_i);
         #1;
         if (bus.valid_o) begin
            lat  = i;
            seen = 1'b1;
         end
         i++;
      end
   endtask

   task automatic handover();
      @(negedge clk_i);
      bus.ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      checks++; if (bus.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
      checks++; if ({bus.sign_o, bus.eff_sub_o, bus.exp_o, bus.sticky_o, bus.exception_o} !== 15'h0) begin
         failures++; $display("FAIL reset_ctrl got=%h exp=0", {bus.sign_o, bus.eff_sub_o, bus.exp_o, bus.sticky_o, bus.exception_o}); end
      checks++; if ({bus.man_big_o, bus.man_small_o} !== 48'h0) begin
         failures++; $display("FAIL reset_man got=%h exp=0", {bus.man_big_o, bus.man_small_o}); end
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_equal();
      int lat;
      run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, lat);
      checks++; if (lat != 1) begin failures++; $display("FAIL equal_lat got=%0d exp=1", lat); end
      checks++; if (bus.exp_o !== 8'h7F) begin failures++; $display("FAIL equal_exp got=%h exp=7f", bus.exp_o); end
      checks++; if (bus.man_big_o !== 24'h800000 || bus.man_small_o !== 24'h800000) begin
         failures++; $display("FAIL equal_man got=%h/%h exp=800000/800000", bus.man_big_o, bus.man_small_o); end
      checks++; if ({bus.eff_sub_o, bus.sticky_o, bus.exception_o, bus.sign_o} !== 7'b0) begin
         failures++; $display("FAIL equal_flags got=%b exp=0000000", {bus.eff_sub_o, bus.sticky_o, bus.exception_o, bus.sign_o}); end
      handover();
   endtask

   task automatic test_align();
      int lat;
      run_op(32'h3F80_0000, 32'h3E80_0000, 1'b0, lat);
      checks++; if (lat != 3) begin failures++; $display("FAIL align2_lat got=%0d exp=3", lat); end
      checks++; if (bus.man_small_o !== 24'h200000 || bus.sticky_o !== 1'b0) begin
         failures++; $display("FAIL align2_small got=%h/%b exp=200000/0", bus.man_small_o, bus.sticky_o); end
      checks++; if (bus.exp_o !== 8'h7F || bus.man_big_o !== 24'h800000) begin
         failures++; $display("FAIL align2_big got=%h/%h exp=7f/800000", bus.exp_o, bus.man_big_o); end
      handover();
      run_op(32'h3F80_0000, 32'h3080_0001, 1'b0, lat);
      checks++; if (lat != 26) begin failures++; $display("FAIL alignmax_lat got=%0d exp=26", lat); end
      checks++; if (bus.man_small_o !== 24'h0 || bus.sticky_o !== 1'b1) begin
         failures++; $display("FAIL alignmax_small got=%h/%b exp=000000/1", bus.man_small_o, bus.sticky_o); end
      handover();
   endtask

   task automatic test_swap();
      int lat;
      run_op(32'h3E80_0003, 32'hC000_0000, 1'b1, lat);
      checks++; if (lat != 4) begin failures++; $display("FAIL swap_lat got=%0d exp=4", lat); end
      checks++; if (bus.exp_o !== 8'h80 || bus.man_big_o !== 24'h800000) begin
         failures++; $display("FAIL swap_big got=%h/%h exp=80/800000", bus.exp_o, bus.man_big_o); end
      checks++; if (bus.man_small_o !== 24'h100000 || bus.sticky_o !== 1'b1) begin
         failures++; $display("FAIL swap_small got=%h/%b exp=100000/1", bus.man_small_o, bus.sticky_o); end
      checks++; if (bus.sign_o !== 1'b0 || bus.eff_sub_o !== 1'b0) begin
         failures++; $display("FAIL swap_sign got=%b%b exp=00", bus.sign_o, bus.eff_sub_o); end
      handover();
      run_op(32'h3FC0_0000, 32'hBFE0_0000, 1'b0, lat);
      checks++; if (lat != 1) begin failures++; $display("FAIL mtie_lat got=%0d exp=1", lat); end
      checks++; if (bus.man_big_o !== 24'hE00000 || bus.man_small_o !== 24'hC00000) begin
         failures++; $display("FAIL mtie_man got=%h/%h exp=e00000/c00000", bus.man_big_o, bus.man_small_o); end
      checks++; if (bus.sign_o !== 1'b1 || bus.eff_sub_o !== 1'b1) begin
         failures++; $display("FAIL mtie_sign got=%b%b exp=11", bus.sign_o, bus.eff_sub_o); end
      handover();
      run_op(32'h0000_0001, 32'h0080_0000, 1'b0, lat);
      checks++; if (lat != 1) begin failures++; $display("FAIL denorm_lat got=%0d exp=1", lat); end
      checks++; if (bus.exp_o !== 8'h01 || bus.man_big_o !== 24'h800000 || bus.man_small_o !== 24'h000001) begin
         failures++; $display("FAIL denorm_val got=%h/%h/%h exp=01/800000/000001", bus.exp_o, bus.man_big_o, bus.man_small_o); end
      checks++; if (bus.exception_o !== EXC_NONE) begin failures++; $display("FAIL denorm_exc got=%b exp=0000", bus.exception_o); end
      handover();
   endtask

   task automatic test_exceptions();
      int lat;
      run_op(32'h7F80_0000, 32'h7F80_0000, 1'b1, lat);
      checks++; if (lat != 1) begin failures++; $display("FAIL infsub_lat got=%0d exp=1", lat); end
      checks++; if (bus.exception_o !== 4'b0001 || bus.eff_sub_o !== 1'b1) begin
         failures++; $display("FAIL infsub_exc got=%b/%b exp=0001/1", bus.exception_o, bus.eff_sub_o); end
      handover();
      run_op(32'hFF80_0000, 32'h3F80_0000, 1'b0, lat);
      checks++; if (lat != 1 || bus.exception_o !== 4'b0010 || bus.sign_o !== 1'b1) begin
         failures++; $display("FAIL inf got=%0d/%b/%b exp=1/0010/1", lat, bus.exception_o, bus.sign_o); end
      handover();
      run_op(32'h3F80_0000, 32'h7FC0_0000, 1'b0, lat);
      checks++; if (lat != 1 || bus.exception_o !== 4'b0001) begin
         failures++; $display("FAIL nan got=%0d/%b exp=1/0001", lat, bus.exception_o); end
      handover();
      run_op(32'h0000_0000, 32'h3F80_0000, 1'b0, lat);
      checks++; if (lat != 1 || bus.exception_o !== 4'b0100) begin
         failures++; $display("FAIL azero got=%0d/%b exp=1/0100", lat, bus.exception_o); end
      handover();
      run_op(32'h4000_0000, 32'h0000_0000, 1'b0, lat);
      checks++; if (lat != 1 || bus.exception_o !== 4'b1000) begin
         failures++; $display("FAIL bzero got=%0d/%b exp=1/1000", lat, bus.exception_o); end
      handover();
      run_op(32'h0000_0000, 32'h8000_0000, 1'b0, lat);
      checks++; if (lat != 1 || bus.exception_o !== 4'b0100) begin
         failures++; $display("FAIL bothzero got=%0d/%b exp=1/0100", lat, bus.exception_o); end
      handover();
   endtask

   task automatic test_stall();
      int lat;
      run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, lat);
      checks++; if (lat != 1) begin failures++; $display("FAIL stall_lat got=%0d exp=1", lat); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         bus.valid_i = 1'b1; bus.a_i = 32'h4040_0000; bus.b_i = 32'h3E00_0000; bus.ready_i = 1'b0;
         @(posedge clk_i);
         #1;
         checks++; if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0) begin
            failures++; $display("FAIL stall_hs cyc=%0d got=%b%b exp=10", c, bus.valid_o, bus.ready_o); end
         checks++; if (bus.exp_o !== 8'h7F || bus.man_big_o !== 24'h800000 || bus.man_small_o !== 24'h800000 || bus.exception_o !== 4'b0) begin
            failures++; $display("FAIL stall_hold cyc=%0d got=%h/%h/%h/%b exp=7f/800000/800000/0000",
                                 c, bus.exp_o, bus.man_big_o, bus.man_small_o, bus.exception_o); end
      end
      @(negedge clk_i);
      bus.ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.ready_i = 1'b0;
      checks++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
         failures++; $display("FAIL stall_handover got=%b%b exp=01", bus.valid_o, bus.ready_o); end
      bus.valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      checks++; if (bus.ready_o !== 1'b1) begin
         failures++; $display("FAIL stall_noaccept got=%b exp=1", bus.ready_o); end
   endtask

   task automatic test_reset_align();
      bit seen_valid = 1'b0;
      @(negedge clk_i);
      bus.a_i = 32'h3F80_0000; bus.b_i = 32'h3A80_0000; bus.sub_i = 1'b0; bus.valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.valid_i = 1'b0;
      repeat (3) begin
         @(posedge clk_i);
         #1;
         if (bus.valid_o) seen_valid = 1'b1;
      end
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      checks++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
         failures++; $display("FAIL rstalign_state got=%b%b exp=10", bus.ready_o, bus.valid_o); end
      checks++; if (bus.man_small_o !== 24'h0 || bus.exp_o !== 8'h0) begin
         failures++; $display("FAIL rstalign_data got=%h/%h exp=000000/00", bus.man_small_o, bus.exp_o); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (15) begin
         @(posedge clk_i);
         #1;
         if (bus.valid_o) seen_valid = 1'b1;
      end
      checks++; if (seen_valid !== 1'b0 || bus.ready_o !== 1'b1) begin
         failures++; $display("FAIL rstalign_novalid got=%b/%b exp=0/1", seen_valid, bus.ready_o); end
   endtask

   task automatic test_back_to_back();
      int lat;
      run_op(32'h3F80_0000, 32'h3F00_0000, 1'b1, lat);
      checks++; if (lat != 2 || bus.man_small_o !== 24'h400000 || bus.eff_sub_o !== 1'b1) begin
         failures++; $display("FAIL b2b_first got=%0d/%h/%b exp=2/400000/1", lat, bus.man_small_o, bus.eff_sub_o); end
      handover();
      run_op(32'h4100_0000, 32'h3F80_0000, 1'b0, lat);
      checks++; if (lat != 4 || bus.exp_o !== 8'h82 || bus.man_small_o !== 24'h100000) begin
         failures++; $display("FAIL b2b_second got=%0d/%h/%h exp=4/82/100000", lat, bus.exp_o, bus.man_small_o); end
      handover();
   endtask

   initial begin
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.sub_i   = 1'b0;
      test_reset();
      test_equal();
      test_align();
      test_swap();
      test_exceptions();
      test_stall();
      test_reset_align();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
